// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Fetch-stage controller for a 64-bit, 5-stage pipeline. Each cycle it picks
// the next PC (sequential or branch target) and drives the write enables and
// bubble controls of the front-end pipeline registers. It resolves memory
// stalls, load-use hazards and taken branches. When a fetch would leave the
// legal program window it stops fetching, lets in-flight work retire for a
// fixed number of cycles, and then halts.
//
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high
//   pc_cur         in   XLEN   current PC register value
//   branch_taken   in   1      EX stage resolved a taken branch/jump
//   branch_target  in   XLEN   EX stage target address
//   idex_mem_read  in   1      ID/EX instruction is a load
//   idex_rd        in   5      ID/EX destination register
//   ifid_rs1       in   5      IF/ID source register 1
//   ifid_rs2       in   5      IF/ID source register 2
//   mem_busy       in   1      memory not ready; freeze the front end
//   pc_next        out  XLEN   value to load into the PC register
//   pc_write       out  1      PC register write enable
//   ifid_write     out  1      IF/ID register write enable
//   ifid_flush     out  1      IF/ID becomes a bubble
//   idex_flush     out  1      ID/EX becomes a bubble
//   halted         out  1      registered; sequencer is in HALT
//   halt_cause     out  2      registered; 0 none, 1 PC beyond limit, 2 misaligned
//   stall_count    out  CNT_W  registered; saturating count of RUN stall cycles
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int XLEN         = 64,
    parameter int PC_LIMIT     = 260,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_cur,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             mem_busy,
    output logic [XLEN-1:0]  pc_next,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] stall_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [XLEN-1:0]    PC_LIMIT_V   = XLEN'(PC_LIMIT);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD   = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STALL_MAX    = '1;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_LIMIT = 2'd1;
    localparam logic [1:0] CAUSE_ALIGN = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [DRAIN_W-1:0] drain_cnt_q,   drain_cnt_d;
    logic               halted_q,      halted_d;
    logic [1:0]         halt_cause_q,  halt_cause_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    // ------------------------------------------------------------------
    // Next-PC candidate and its legality. The +4 wraps modulo 2^XLEN;
    // a wrapped value is then judged by the same window check.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] pc_cand;
    logic            cand_over_limit;
    logic            cand_misaligned;
    logic            cand_illegal;
    logic [1:0]      cand_cause;
    logic            load_use;

    always_comb begin
        pc_cand         = branch_taken ? branch_target : (pc_cur + XLEN'(4));
        cand_over_limit = (pc_cand > PC_LIMIT_V);
        cand_misaligned = (pc_cand[1:0] != 2'b00);
        cand_illegal    = cand_over_limit || cand_misaligned;
        // An address that is both out of range and misaligned reports the
        // range violation, as that is the more fundamental fault.
        cand_cause      = cand_over_limit ? CAUSE_LIMIT :
                          (cand_misaligned ? CAUSE_ALIGN : CAUSE_NONE);
        load_use        = idex_mem_read && (idex_rd != 5'd0) &&
                          ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        halt_cause_d  = halt_cause_q;
        stall_count_d = stall_count_q;
        halted_d      = halted_q;

        pc_next    = pc_cand;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    // Full freeze; any pending branch is still presented by
                    // EX and gets acted on once memory is ready.
                    if (stall_count_q != STALL_MAX) begin
                        stall_count_d = stall_count_q + CNT_W'(1);
                    end
                end else if (branch_taken || !load_use) begin
                    // Cases that would write the PC: taken branch (which
                    // overrides a load-use hazard) or straight-line fetch.
                    ifid_write = 1'b1;
                    ifid_flush = branch_taken;
                    idex_flush = branch_taken;
                    if (cand_illegal) begin
                        // Stop fetching; the IF/ID instruction still moves on
                        // but nothing new is fetched behind it.
                        pc_write     = 1'b0;
                        ifid_flush   = 1'b1;
                        state_d      = ST_DRAIN;
                        drain_cnt_d  = DRAIN_LOAD;
                        halt_cause_d = cand_cause;
                    end else begin
                        pc_write = 1'b1;
                    end
                end else begin
                    // Load-use: hold PC and IF/ID, inject one bubble into
                    // ID/EX. The load moves on, so the hazard clears next cycle.
                    idex_flush = 1'b1;
                    if (stall_count_q != STALL_MAX) begin
                        stall_count_d = stall_count_q + CNT_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                ifid_flush = 1'b1;
                ifid_write = 1'b1;
                if (mem_busy) begin
                    ifid_write = 1'b0;
                end else if (branch_taken && !cand_illegal) begin
                    // A late legal branch pulls the program back into range.
                    pc_write     = 1'b1;
                    idex_flush   = 1'b1;
                    halt_cause_d = CAUSE_NONE;
                    state_d      = ST_RUN;
                end else if (branch_taken) begin
                    // Illegal target: squash the wrong path and remember why
                    // the program is ending; the drain timer does not advance.
                    idex_flush   = 1'b1;
                    halt_cause_d = cand_cause;
                end else if (drain_cnt_q == '0) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end

            ST_HALT: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                halted_d   = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset overrides the front-end controls for as long as it is held.
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= '0;
            halted_q      <= 1'b0;
            halt_cause_q  <= CAUSE_NONE;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            halted_q      <= halted_d;
            halt_cause_q  <= halt_cause_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign halted      = halted_q;
    assign halt_cause  = halt_cause_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Directed bench for pc_fetch_sequencer. Inputs change 1 ns after each rising
// edge; combinational outputs are checked 1 ns later, registered outputs are
// checked after the following edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [XLEN-1:0]  pc_cur;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             idex_mem_read;
    logic [4:0]       idex_rd;
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             mem_busy;
    logic [XLEN-1:0]  pc_next;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .XLEN(XLEN), .PC_LIMIT(260), .DRAIN_CYCLES(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .mem_busy(mem_busy),
        .pc_next(pc_next), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
        .halt_cause(halt_cause), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-24s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Front-end control bundle {pc_write, ifid_write, ifid_flush, idex_flush}.
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {60'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {60'd0, exp});
    endtask

    task automatic check_regs(input string tag, input logic hlt, input logic [1:0] cause,
                              input logic [CNT_W-1:0] cnt);
        check({tag, ".halted"}, {63'd0, halted}, {63'd0, hlt});
        check({tag, ".cause"},  {62'd0, halt_cause}, {62'd0, cause});
        check({tag, ".stalls"}, {32'd0, stall_count}, {32'd0, cnt});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        branch_taken  = 1'b0;
        branch_target = '0;
        idex_mem_read = 1'b0;
        idex_rd       = 5'd0;
        ifid_rs1      = 5'd0;
        ifid_rs2      = 5'd0;
        mem_busy      = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        pc_cur = '0;
        clear_inputs();

        // ---------------- reset state ----------------
        step(); #1;
        check_ctl("reset_ctl", 4'b0011);
        check_regs("reset", 1'b0, 2'd0, 32'd0);

        // ---------------- straight-line code ----------------
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_cur = 64'(i * 4); #1;
            check("seq_pc_next", pc_next, 64'(i * 4 + 4));
            check_ctl("seq_ctl", 4'b1100);
            step();
        end
        pc_cur = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        check("wrap_pc_next", pc_next, 64'd0);
        check_ctl("wrap_ctl", 4'b1100);
        step();
        check("seq_stalls", {32'd0, stall_count}, 64'd0);

        // ---------------- load-use hazards ----------------
        pc_cur = 64'd12; idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; #1;
        check_ctl("lu_rs2_ctl", 4'b0001);
        step();
        check("lu_rs2_stalls", {32'd0, stall_count}, 64'd1);
        idex_rd = 5'd0; #1;
        check_ctl("lu_x0_ctl", 4'b1100);
        step();
        check("lu_x0_stalls", {32'd0, stall_count}, 64'd1);
        idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_rs2 = 5'd3; #1;
        check_ctl("lu_rs1_ctl", 4'b0001);
        step();
        check("lu_rs1_stalls", {32'd0, stall_count}, 64'd2);
        idex_mem_read = 1'b0; #1;
        check_ctl("no_load_ctl", 4'b1100);
        step();

        // ---------------- branch beats load-use ----------------
        idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
        branch_taken = 1'b1; branch_target = 64'h40; #1;
        check("br_pc_next", pc_next, 64'h40);
        check_ctl("br_ctl", 4'b1111);
        step();
        check("br_stalls", {32'd0, stall_count}, 64'd2);

        // ---------------- memory busy freezes, branch acted on later ----------------
        mem_busy = 1'b1; #1;
        check_ctl("busy1_ctl", 4'b0000);
        step();
        check_ctl("busy2_ctl", 4'b0000);
        step();
        check("busy_stalls", {32'd0, stall_count}, 64'd4);
        mem_busy = 1'b0; #1;
        check("busy_rel_pc_next", pc_next, 64'h40);
        check_ctl("busy_rel_ctl", 4'b1111);
        step();
        check("busy_rel_stalls", {32'd0, stall_count}, 64'd4);
        clear_inputs();

        // ---------------- end of program: limit, drain, halt ----------------
        pc_cur = 64'd256; #1;
        check("at_limit_pc_next", pc_next, 64'd260);
        check_ctl("at_limit_ctl", 4'b1100);
        step();
        pc_cur = 64'd260; #1;
        check("over_pc_next", pc_next, 64'd264);
        check_ctl("over_ctl", 4'b0110);
        step();
        check_regs("drain_entry", 1'b0, 2'd1, 32'd4);
        check_ctl("drain_ctl", 4'b0110);
        step(); step(); step();
        check_regs("drain_3", 1'b0, 2'd1, 32'd4);
        step();
        check_regs("halt", 1'b1, 2'd1, 32'd4);
        check_ctl("halt_ctl", 4'b0011);
        branch_taken = 1'b1; branch_target = 64'h20; mem_busy = 1'b1; #1;
        check_ctl("halt_br_ctl", 4'b0011);
        step(); step();
        check_regs("halt_hold", 1'b1, 2'd1, 32'd4);
        clear_inputs();

        // ---------------- reset from HALT ----------------
        reset = 1'b1;
        step();
        reset = 1'b0; pc_cur = '0; #1;
        check_regs("rst_halt", 1'b0, 2'd0, 32'd0);
        check_ctl("rst_halt_ctl", 4'b1100);
        step();

        // ---------------- legal branch during DRAIN returns to RUN ----------------
        pc_cur = 64'd260;
        step();
        step();
        branch_taken = 1'b1; branch_target = 64'h10; #1;
        check("drain_br_pc_next", pc_next, 64'h10);
        check_ctl("drain_br_ctl", 4'b1111);
        step();
        check_regs("drain_br", 1'b0, 2'd0, 32'd0);
        clear_inputs(); pc_cur = 64'h10; #1;
        check("rerun_pc_next", pc_next, 64'h14);
        check_ctl("rerun_ctl", 4'b1100);
        step();

        // ---------------- misaligned branch during DRAIN ----------------
        pc_cur = 64'd260;
        step();
        branch_taken = 1'b1; branch_target = 64'h12; #1;
        check_ctl("drain_bad_ctl", 4'b0111);
        step();
        check_regs("drain_bad", 1'b0, 2'd2, 32'd0);
        clear_inputs();
        step(); step(); step();
        check("drain_bad_3", {63'd0, halted}, 64'd0);
        step();
        check_regs("halt_align", 1'b1, 2'd2, 32'd0);

        // ---------------- reset mid-DRAIN ----------------
        reset = 1'b1;
        step();
        reset = 1'b0; pc_cur = '0; mem_busy = 1'b1;
        step();
        check("pre_drain_stalls", {32'd0, stall_count}, 64'd1);
        mem_busy = 1'b0; branch_taken = 1'b1; branch_target = 64'h102; #1;
        check_ctl("run_misalign_ctl", 4'b0111);
        step();
        check_regs("run_misalign", 1'b0, 2'd2, 32'd1);
        clear_inputs();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; pc_cur = 64'd8; #1;
        check_regs("rst_drain", 1'b0, 2'd0, 32'd0);
        check("rst_drain_pc_next", pc_next, 64'd12);
        check_ctl("rst_drain_ctl", 4'b1100);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
